// File: rtl/text_lcd_2_pkg.sv
// text_lcd_2_pkg
// Shared definitions for the text LCD calculator:
//   - HD44780 command bytes used by the init and refresh sequence
//   - ASCII codes for every character the display can show
//   - entry FSM state and operator encodings
//   - decodeKey: one-hot digit key decoder
package text_lcd_2_pkg;

  localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY = 8'h06;  // increment address, no shift
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_MUL   = 8'h2A;
  localparam logic [7:0] CH_DIV   = 8'h2F;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_0     = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    GOT_A,
    GOT_OP,
    GOT_B,
    RESULT
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  // Returns {valid, digit}. Only an exact one-hot pattern is a digit; zero,
  // multiple or unknown bits never match any equality and so decode as invalid.
  function automatic logic [4:0] decodeKey(input logic [9:0] key);
    logic [4:0] r;
    r = 5'b0;
    for (int i = 0; i < 10; i++) begin
      if (key == (10'd1 << i)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/text_lcd_2_if.sv
// text_lcd_2_if
// Bundles the calculator keypad inputs and the LCD/LED outputs.
//   set, KEY[9:0], Add, Sub, Mul, Div : keypad side (driven by master)
//   lcd_rs, lcd_rw, lcd_en, lcd_data  : HD44780 bus (driven by slave)
//   lcd_p, lcd_n                      : backlight supply
//   led[4:0]                          : status lamps
interface text_lcd_2_if;
  logic       set;
  logic [9:0] KEY;
  logic       Add;
  logic       Sub;
  logic       Mul;
  logic       Div;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       lcd_p;
  logic       lcd_n;
  logic [4:0] led;

  modport master (
    output set, KEY, Add, Sub, Mul, Div,
    input  lcd_rs, lcd_rw, lcd_en, lcd_data, lcd_p, lcd_n, led
  );

  modport slave (
    input  set, KEY, Add, Sub, Mul, Div,
    output lcd_rs, lcd_rw, lcd_en, lcd_data, lcd_p, lcd_n, led
  );
endinterface

// File: rtl/text_lcd_2_drv.sv
// text_lcd_2_drv
// LCD timing and sequencer. Each step lasts TICK_DIV clocks; rs/data are
// loaded at the start of a step and held, en is high in the second half.
// Steps 0..3 are the init commands, step 4 is a quiet step, then steps
// 5..38 loop forever: line-1 address, 16 chars, line-2 address, 16 chars.
//   clk, rst_n   : clock, async active-low reset
//   text_i       : 32 live characters, [0..15] line 1, [16..31] line 2
//   lcd_rs_o, lcd_en_o, lcd_data_o : LCD bus
module text_lcd_2_drv
  import text_lcd_2_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0][7:0] text_i,
  output logic            lcd_rs_o,
  output logic            lcd_en_o,
  output logic [7:0]      lcd_data_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [5:0] STEP_IDLE  = 6'd4;
  localparam logic [5:0] STEP_LINE1 = 6'd5;
  localparam logic [5:0] STEP_LINE2 = 6'd22;
  localparam logic [5:0] STEP_LAST  = 6'd38;
  // Parked here during reset so the very first tick lands on step 0.
  localparam logic [5:0] STEP_PRE   = 6'd63;

  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    step_q, step_d;
  logic          tickWrap;
  logic          stepRs;
  logic [7:0]    stepData;
  logic          rs_q, en_q;
  logic [7:0]    data_q;

  always_comb begin
    tickWrap = (tick_q == TW'(TICK_DIV - 1));
    tick_d   = tickWrap ? '0 : tick_q + 1'b1;
    step_d   = step_q;
    if (tickWrap) begin
      if (step_q == STEP_PRE)       step_d = 6'd0;
      else if (step_q == STEP_LAST) step_d = STEP_LINE1;
      else                          step_d = step_q + 6'd1;
    end
  end

  // Bus contents for the step about to begin.
  always_comb begin
    stepRs   = 1'b0;
    stepData = 8'h00;
    case (step_d)
      6'd0:       stepData = CMD_FUNC;
      6'd1:       stepData = CMD_DISP;
      6'd2:       stepData = CMD_ENTRY;
      6'd3:       stepData = CMD_CLEAR;
      STEP_IDLE:  stepData = 8'h00;
      STEP_LINE1: stepData = CMD_LINE1;
      STEP_LINE2: stepData = CMD_LINE2;
      default: begin
        stepRs = 1'b1;
        if (step_d < STEP_LINE2) stepData = text_i[5'(step_d - 6'd6)];
        else                     stepData = text_i[5'(step_d - 6'd7)];
      end
    endcase
  end

  // Outputs are registered so reset clears them at once and data never
  // changes while en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= TW'(TICK_DIV - 1);
      step_q <= STEP_PRE;
      rs_q   <= 1'b0;
      en_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      tick_q <= tick_d;
      step_q <= step_d;
      en_q   <= (tick_d >= TW'(TICK_DIV / 2)) && (step_d != STEP_IDLE);
      if (tickWrap) begin
        rs_q   <= stepRs;
        data_q <= stepData;
      end
    end
  end

  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/text_lcd_2.sv
// text_lcd_2
// Single-digit calculator on a 16x2 text LCD. A synchronised rising edge
// of set commits the current digit/operator into the entry FSM; the
// resulting expression and answer are rendered into a 32-char buffer
// that text_lcd_2_drv streams to the display.
//   clk, rst_n : clock, async active-low reset
//   lcd_if     : keypad inputs, LCD bus, backlight and led status
module text_lcd_2
  import text_lcd_2_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  text_lcd_2_if.slave  lcd_if
);

  logic       setMeta_q, setSync_q, setPrev_q;
  logic       setRise;
  logic [4:0] keyDec;
  logic       digitValid;
  logic [3:0] digit;
  logic       opValid;
  op_e        opSel;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  op_e        op_q, op_d;
  logic [6:0] resMag_q, resMag_d;
  logic       resNeg_q, resNeg_d, err_q, err_d;

  logic [6:0] calcMag;
  logic       calcNeg, calcErr;
  logic [6:0] tens, ones;
  logic [4:0] pos;
  logic [31:0][7:0] text;

  // Two-flop synchroniser plus edge detector on the asynchronous strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setMeta_q <= 1'b0;
      setSync_q <= 1'b0;
      setPrev_q <= 1'b0;
    end else begin
      setMeta_q <= lcd_if.set;
      setSync_q <= setMeta_q;
      setPrev_q <= setSync_q;
    end
  end

  assign setRise    = setSync_q & ~setPrev_q;
  assign keyDec     = decodeKey(lcd_if.KEY);
  assign digitValid = keyDec[4];
  assign digit      = keyDec[3:0];
  assign opValid    = lcd_if.Add | lcd_if.Sub | lcd_if.Mul | lcd_if.Div;

  always_comb begin
    opSel = OP_DIV;
    if (lcd_if.Add)      opSel = OP_ADD;
    else if (lcd_if.Sub) opSel = OP_SUB;
    else if (lcd_if.Mul) opSel = OP_MUL;
  end

  // Arithmetic on the held operands; results are magnitude plus sign.
  always_comb begin
    calcMag = 7'd0;
    calcNeg = 1'b0;
    calcErr = 1'b0;
    case (op_q)
      OP_ADD: calcMag = 7'(a_q) + 7'(b_q);
      OP_SUB: begin
        if (a_q >= b_q) calcMag = 7'(a_q - b_q);
        else begin
          calcMag = 7'(b_q - a_q);
          calcNeg = 1'b1;
        end
      end
      OP_MUL: calcMag = 7'(a_q) * 7'(b_q);
      OP_DIV: begin
        if (b_q == 4'd0) calcErr = 1'b1;
        else             calcMag = 7'(a_q / b_q);
      end
      default: calcMag = 7'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= OP_ADD;
      resMag_q <= 7'd0;
      resNeg_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      resMag_q <= resMag_d;
      resNeg_q <= resNeg_d;
      err_q    <= err_d;
    end
  end

  // Entry FSM: each committed strobe either advances or replaces the
  // operand/operator currently being edited.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    resMag_d = resMag_q;
    resNeg_d = resNeg_q;
    err_d    = err_q;
    if (setRise) begin
      case (state_q)
        IDLE: begin
          if (digitValid) begin
            a_d     = digit;
            state_d = GOT_A;
          end
        end
        GOT_A: begin
          if (opValid) begin
            op_d    = opSel;
            state_d = GOT_OP;
          end else if (digitValid) begin
            a_d = digit;
          end
        end
        GOT_OP: begin
          if (digitValid) begin
            b_d     = digit;
            state_d = GOT_B;
          end else if (opValid) begin
            op_d = opSel;
          end
        end
        GOT_B: begin
          if (digitValid) begin
            b_d = digit;
          end else if (!opValid) begin
            resMag_d = calcMag;
            resNeg_d = calcNeg;
            err_d    = calcErr;
            state_d  = RESULT;
          end
        end
        RESULT: begin
          if (digitValid) begin
            a_d      = digit;
            b_d      = 4'd0;
            op_d     = OP_ADD;
            resMag_d = 7'd0;
            resNeg_d = 1'b0;
            err_d    = 1'b0;
            state_d  = GOT_A;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign tens = resMag_q / 7'd10;
  assign ones = resMag_q % 7'd10;

  // Display buffer: expression on line 1, answer on line 2, spaces elsewhere.
  always_comb begin
    text = {32{CH_SPACE}};
    pos  = 5'd17;
    if (state_q != IDLE) text[0] = CH_0 + {4'd0, a_q};
    if (state_q == GOT_OP || state_q == GOT_B || state_q == RESULT) begin
      case (op_q)
        OP_ADD:  text[1] = CH_PLUS;
        OP_SUB:  text[1] = CH_MINUS;
        OP_MUL:  text[1] = CH_MUL;
        default: text[1] = CH_DIV;
      endcase
    end
    if (state_q == GOT_B || state_q == RESULT) text[2] = CH_0 + {4'd0, b_q};
    if (state_q == RESULT) begin
      text[16] = CH_EQ;
      if (err_q) begin
        text[17] = CH_E;
        text[18] = CH_R;
        text[19] = CH_R;
      end else begin
        if (resNeg_q) begin
          text[pos] = CH_MINUS;
          pos = pos + 5'd1;
        end
        if (tens != 7'd0) begin
          text[pos] = CH_0 + {1'b0, tens};
          pos = pos + 5'd1;
        end
        text[pos] = CH_0 + {1'b0, ones};
      end
    end
  end

  text_lcd_2_drv #(
    .TICK_DIV (TICK_DIV)
  ) u_drv (
    .clk        (clk),
    .rst_n      (rst_n),
    .text_i     (text),
    .lcd_rs_o   (lcd_if.lcd_rs),
    .lcd_en_o   (lcd_if.lcd_en),
    .lcd_data_o (lcd_if.lcd_data)
  );

  assign lcd_if.lcd_rw = 1'b0;
  assign lcd_if.lcd_p  = 1'b1;
  assign lcd_if.lcd_n  = 1'b0;
  assign lcd_if.led    = {err_q & (state_q == RESULT),
                          ~err_q & (state_q == RESULT),
                          state_q == GOT_B,
                          state_q == GOT_OP,
                          state_q == GOT_A};

endmodule

// File: tb/tb_text_lcd_2.sv
// tb_text_lcd_2
// Directed bench for text_lcd_2 with a short LCD step. A small LCD model
// decodes the bus (address commands and character writes) into a 32-char
// screen so the displayed lines can be compared with hand-written strings.
module tb_text_lcd_2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  text_lcd_2_if lcdIf ();

  text_lcd_2 #(
    .TICK_DIV (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lcd_if (lcdIf)
  );

  int checks = 0;
  int passes = 0;
  int cycleCnt = 0;

  logic [7:0] screen [32];
  int         addr;
  logic       enPrev;
  logic [8:0] capQ [$];
  int         capCyc [$];

  always @(posedge clk) cycleCnt++;

  // LCD model: every rising edge of en is one bus write.
  always @(negedge clk) begin
    if (!rst_n) begin
      capQ.delete();
      capCyc.delete();
      addr   = 0;
      enPrev = 1'b0;
      for (int i = 0; i < 32; i++) screen[i] = 8'h00;
    end else begin
      if (lcdIf.lcd_en && !enPrev) begin
        capQ.push_back({lcdIf.lcd_rs, lcdIf.lcd_data});
        capCyc.push_back(cycleCnt);
        if (!lcdIf.lcd_rs) begin
          if (lcdIf.lcd_data == 8'h80)      addr = 0;
          else if (lcdIf.lcd_data == 8'hC0) addr = 16;
        end else begin
          screen[addr] = lcdIf.lcd_data;
          addr = (addr + 1) % 32;
        end
      end
      enPrev = lcdIf.lcd_en;
    end
  end

  function automatic logic [127:0] lineOf(input int ln);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = screen[ln*16 + i];
    return r;
  endfunction

  function automatic logic [127:0] pad(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [8:0] capAt(input int i);
    return (i < capQ.size()) ? capQ[i] : 9'h1FF;
  endfunction

  function automatic int cycAt(input int i);
    return (i < capCyc.size()) ? capCyc[i] : -1000;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Present a key/operator pattern, strobe set, then release everything.
  task automatic applyStimulus(input logic [9:0] keyVal, input logic [3:0] ops);
    @(negedge clk);
    lcdIf.KEY = keyVal;
    {lcdIf.Add, lcdIf.Sub, lcdIf.Mul, lcdIf.Div} = ops;
    repeat (2) @(negedge clk);
    lcdIf.set = 1'b1;
    repeat (4) @(negedge clk);
    lcdIf.set = 1'b0;
    repeat (2) @(negedge clk);
    lcdIf.KEY = 10'd0;
    {lcdIf.Add, lcdIf.Sub, lcdIf.Mul, lcdIf.Div} = 4'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitRefresh();
    repeat (300) @(negedge clk);
  endtask

  function automatic logic [17:0] outPack();
    return {lcdIf.led, lcdIf.lcd_rs, lcdIf.lcd_rw, lcdIf.lcd_en,
            lcdIf.lcd_data, lcdIf.lcd_p, lcdIf.lcd_n};
  endfunction

  task automatic checkInitSequence(input string pfx);
    checkOutput({pfx, "_count"}, 128'(capQ.size() >= 5), 128'(1));
    checkOutput({pfx, "_0"}, 128'(capAt(0)), 128'(9'h038));
    checkOutput({pfx, "_1"}, 128'(capAt(1)), 128'(9'h00C));
    checkOutput({pfx, "_2"}, 128'(capAt(2)), 128'(9'h006));
    checkOutput({pfx, "_3"}, 128'(capAt(3)), 128'(9'h001));
    checkOutput({pfx, "_4"}, 128'(capAt(4)), 128'(9'h080));
    checkOutput({pfx, "_gap01"}, 128'(cycAt(1) - cycAt(0)), 128'(4));
    checkOutput({pfx, "_gap34"}, 128'(cycAt(4) - cycAt(3)), 128'(8));
  endtask

  localparam logic [17:0] RESET_PACK = {5'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    lcdIf.set = 1'b0;
    lcdIf.KEY = 10'd0;
    {lcdIf.Add, lcdIf.Sub, lcdIf.Mul, lcdIf.Div} = 4'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 128'(outPack()), 128'(RESET_PACK));
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkInitSequence("init");

    // 0 + 5 with an unknown key pattern first
    applyStimulus(10'bx, 4'b0000);
    checkOutput("x_key_led", 128'(lcdIf.led), 128'(5'b00000));
    applyStimulus(10'b0000000001, 4'b0000);
    applyStimulus(10'b0000000000, 4'b1000);
    applyStimulus(10'b0000100000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0000);
    checkOutput("add_led", 128'(lcdIf.led), 128'(5'b01000));
    waitRefresh();
    checkOutput("add_line1", lineOf(0), pad("0+5"));
    checkOutput("add_line2", lineOf(1), pad("=5"));

    // 3 - 7
    applyStimulus(10'b0000001000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0100);
    applyStimulus(10'b0010000000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0000);
    waitRefresh();
    checkOutput("sub_line1", lineOf(0), pad("3-7"));
    checkOutput("sub_line2", lineOf(1), pad("=-4"));

    // 9 * 9
    applyStimulus(10'b1000000000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0010);
    applyStimulus(10'b1000000000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0000);
    waitRefresh();
    checkOutput("mul_line2", lineOf(1), pad("=81"));

    // 8 / 3
    applyStimulus(10'b0100000000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0001);
    applyStimulus(10'b0000001000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0000);
    waitRefresh();
    checkOutput("div_line1", lineOf(0), pad("8/3"));
    checkOutput("div_line2", lineOf(1), pad("=2"));

    // 4 / 0
    applyStimulus(10'b0000010000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0001);
    applyStimulus(10'b0000000001, 4'b0000);
    applyStimulus(10'b0000000000, 4'b0000);
    checkOutput("div0_err", 128'(lcdIf.led[4]), 128'(1));
    waitRefresh();
    checkOutput("div0_line2", lineOf(1), pad("=ERR"));

    // new digit from RESULT starts over
    applyStimulus(10'b0000000100, 4'b0000);
    checkOutput("restart_led", 128'(lcdIf.led), 128'(5'b00001));
    waitRefresh();
    checkOutput("restart_line1", lineOf(0), pad("2"));
    checkOutput("restart_line2", lineOf(1), pad(""));

    // asynchronous reset in the middle of refresh
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_reset", 128'(outPack()), 128'(RESET_PACK));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkInitSequence("reinit");

    // two keys at once in IDLE are not a digit
    applyStimulus(10'b0000000011, 4'b0000);
    checkOutput("multi_key_led", 128'(lcdIf.led), 128'(5'b00000));
    waitRefresh();
    checkOutput("multi_key_line1", lineOf(0), pad(""));

    // replace A, operator priority, replace B
    applyStimulus(10'b0000000010, 4'b0000);
    applyStimulus(10'b0001000000, 4'b0000);
    applyStimulus(10'b0000000000, 4'b1010);
    applyStimulus(10'b0000000100, 4'b0000);
    applyStimulus(10'b0000001000, 4'b0000);
    checkOutput("gotb_led", 128'(lcdIf.led), 128'(5'b00100));
    applyStimulus(10'b0000000000, 4'b0000);
    waitRefresh();
    checkOutput("replace_line1", lineOf(0), pad("6+3"));
    checkOutput("replace_line2", lineOf(1), pad("=9"));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/text_lcd_2.md
TEXT_LCD_2 -- requirements
Module: text_lcd_2

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set the clk cycles per LCD step (1 ms at 50 MHz); benches may override it with a small value.
REQ-002 clk  input  1  system clock, 50 MHz nominal.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 set  input  1  asynchronous "enter" strobe; its rising edge commits the current key or operator.
REQ-005 KEY  input  10  one-hot digit keys; KEY[i] set means digit i.
REQ-006 Add, Sub, Mul, Div  input  1 each  operator keys, active high.
REQ-007 lcd_rs, lcd_rw, lcd_en  output  1 each  HD44780-style control (register select, read/write, enable).
REQ-008 lcd_data  output  8  LCD data bus.
REQ-009 lcd_p, lcd_n  output  1 each  backlight supply; lcd_p SHALL be constant 1 and lcd_n constant 0.
REQ-010 led  output  5  status: [0] A held, [1] op held, [2] B held, [3] result valid, [4] error.

Function
REQ-011 set SHALL pass through a 2-FF synchronizer followed by rising-edge detection; every other input is sampled on the edge-detect cycle, and state SHALL update within 3 clk of the set rise.
REQ-012 A digit is valid only when exactly one KEY bit is 1; zero bits, multiple bits or X SHALL be treated as "no digit".
REQ-013 When several operator keys are high, priority SHALL be Add > Sub > Mul > Div.
REQ-014 The entry FSM SHALL have states IDLE, GOT_A, GOT_OP, GOT_B and RESULT.
REQ-015 IDLE: a valid digit SHALL store A and go to GOT_A; any other event SHALL be ignored.
REQ-016 GOT_A: an operator SHALL be stored and the FSM goes to GOT_OP; a valid digit SHALL replace A.
REQ-017 GOT_OP: a valid digit SHALL store B and go to GOT_B; a new operator SHALL replace op.
REQ-018 GOT_B: set with no digit and no operator SHALL compute and go to RESULT; a valid digit SHALL replace B.
REQ-019 RESULT: a valid digit SHALL clear everything, store it as the new A and go to GOT_A; other events SHALL be ignored.
REQ-020 Arithmetic SHALL be on single-digit operands: sum 0..18, signed difference -9..9, product 0..81, integer quotient.
REQ-021 Division by zero SHALL set the error flag (led[4]) and still enter RESULT.
REQ-022 Line 1 SHALL show, from column 0, the entered A, the op character (+ - * /) and B; unentered positions and the rest of the line SHALL be spaces.
REQ-023 Line 2 in RESULT SHALL show "=", a minus sign only if the result is negative, then the decimal result with no leading zeros; on error it SHALL show "=ERR". All other line-2 positions, and all of line 2 in other states, SHALL be spaces.
REQ-024 The LCD driver SHALL advance one step per TICK_DIV cycles.
REQ-025 lcd_en SHALL be high during the second half of each step; lcd_rs and lcd_data SHALL be stable for the whole step.
REQ-026 lcd_rw SHALL be constant 0.
REQ-027 Init sequence (rs=0): 0x38, 0x0C, 0x06, 0x01; the step after 0x01 SHALL be idle with lcd_en low.
REQ-028 After init, refresh SHALL loop forever: 0x80, 16 chars of line 1 (rs=1), 0xC0, 16 chars of line 2 (rs=1).
REQ-029 Characters SHALL be read live, so a display change appears within one refresh loop.

Reset
REQ-030 During rst_n=0: FSM to IDLE; A, B, op and flags cleared; led=0; lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0x00; lcd_p=1, lcd_n=0.
REQ-031 The LCD driver SHALL restart its init sequence at the first step after reset release.
REQ-032 Reset asserted mid-frame SHALL abort the current step immediately.

Structure
REQ-033 A shared package SHALL hold the LCD command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0), the ASCII constants (space, '=', '+', '-', '*', '/', 'E', 'R', '0') and the FSM state enumeration.
REQ-034 The LCD timing/sequencer SHALL be one sub-module, text_lcd_2_drv, that takes a 32-character buffer; entry logic and arithmetic SHALL live in the top module.

Verification
REQ-035 Reset release with TICK_DIV=4 -> lcd_data shows 0x38, 0x0C, 0x06, 0x01 with rs=0, one lcd_en pulse per step, then 0x80.
REQ-036 set with KEY=X, then KEY=0000000001 + set, Add + set, KEY=0000100000 + set, set alone -> led=01000 at the end; line 1 "0+5"; line 2 "=5".
REQ-037 Digits 3, Sub, 7 -> line 2 "=-4"; digits 9, Mul, 9 -> line 2 "=81".
REQ-038 Digit 4, Div, 0 -> led[4]=1 and line 2 "=ERR"; then digit 2 + set -> led=00001 and line 2 cleared.
REQ-039 KEY=0000000011 + set while IDLE -> state stays IDLE and led=0.
REQ-040 rst_n pulsed low mid-refresh -> all outputs take their reset values asynchronously, then init restarts from 0x38.
